// File: rtl/io_uart_pkg.sv
// Shared definitions for the io_uart peripheral.
// Holds the register offsets, the STATUS/CTRL bit positions, the default
// divider and the TX/RX state encodings.
package io_uart_pkg;

  localparam int unsigned ADDR_W      = 2;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned DIV_W       = 16;
  localparam int unsigned DEPTH_LOG2  = 3;
  localparam logic [DIV_W-1:0] DIV_RESET = 16'd433;

  // Register word offsets
  localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_DIV    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int unsigned ST_RX_VALID  = 0;
  localparam int unsigned ST_TX_FULL   = 1;
  localparam int unsigned ST_TX_IDLE   = 2;
  localparam int unsigned ST_RX_OVR    = 3;
  localparam int unsigned ST_FRAME_ERR = 4;
  localparam int unsigned ST_TX_OVF    = 5;

  // CTRL bit positions
  localparam int unsigned CTRL_RX_IE = 0;
  localparam int unsigned CTRL_TX_IE = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/io_uart_if.sv
// CPU IO-bus port of the UART: word address, one-cycle read/write strobes,
// write data in, registered read data out.
//   master: CPU side (drives address/strobes/wdata)
//   slave : peripheral side (drives IO_RDATA)
interface io_uart_if
  import io_uart_pkg::*;
();
  logic [ADDR_W-1:0] IO_ADDR;
  logic              IO_WE;
  logic              IO_RE;
  logic [DATA_W-1:0] IO_WDATA;
  logic [DATA_W-1:0] IO_RDATA;

  modport master (output IO_ADDR, output IO_WE, output IO_RE, output IO_WDATA,
                  input  IO_RDATA);
  modport slave  (input  IO_ADDR, input  IO_WE, input  IO_RE, input  IO_WDATA,
                  output IO_RDATA);
endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO of 2^AW entries of DW bits with a show-ahead head.
//   push_i/wdata_i : write (ignored when full at the start of the cycle)
//   pop_i          : advance head (ignored when empty)
//   rdata_o        : current head, full_o/empty_o/count_o : occupancy
module io_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          push_ok_c, pop_ok_c;

  // Extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok_c = push_i & ~full_o;
  assign pop_ok_c  = pop_i & ~empty_o;

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, programmable divider and a
// level interrupt.
//   CLK, RESET_N : clock, async active-low reset
//   bus          : CPU IO bus (DATA/STATUS/DIVISOR/CTRL at offsets 0..3)
//   UART_RX      : asynchronous serial input, idle high
//   UART_TX      : serial output, idle high
//   IRQ          : registered level interrupt
module io_uart
  import io_uart_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH_LOG2 = DEPTH_LOG2,
  parameter logic [DIV_W-1:0]  DEFAULT_DIV     = DIV_RESET
) (
  input  logic       CLK,
  input  logic       RESET_N,
  io_uart_if.slave   bus,
  input  logic       UART_RX,
  output logic       UART_TX,
  output logic       IRQ
);
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        ctrl_q;
  logic              rx_ovr_q, frm_err_q, tx_ovf_q, irq_q, tx_q;
  logic [DATA_W-1:0] rdata_q;

  tx_state_e         tx_state_q;
  logic [DIV_W-1:0]  tx_cnt_q;
  logic [2:0]        tx_bit_q;
  logic [BYTE_W-1:0] tx_sh_q;

  rx_state_e         rx_state_q;
  logic [DIV_W-1:0]  rx_cnt_q;
  logic [2:0]        rx_bit_q;
  logic [BYTE_W-1:0] rx_sh_q;
  logic              rx_s1_q, rx_s2_q, rx_s3_q;

  logic [BYTE_W-1:0] tx_head, rx_head;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [FIFO_DEPTH_LOG2:0] tx_count, rx_count;

  logic              wr_data_c, rd_data_c, tx_pop_c, tx_idle_c;
  logic              rx_stop_c, rx_push_c, rx_ovr_set_c, frm_err_set_c, tx_ovf_set_c;
  logic [2:0]        clr_c;
  logic [DIV_W-1:0]  rx_half_c;
  logic [DATA_W-1:0] status_c;
  logic              unused_c;

  assign wr_data_c = bus.IO_WE && (bus.IO_ADDR == ADDR_DATA);
  assign rd_data_c = bus.IO_RE && (bus.IO_ADDR == ADDR_DATA);
  assign clr_c     = (bus.IO_WE && (bus.IO_ADDR == ADDR_STATUS)) ? bus.IO_WDATA[5:3] : 3'b000;

  // Shifter takes a byte from IDLE, or straight from the end of STOP for gapless frames.
  assign tx_pop_c  = ~tx_empty && ((tx_state_q == TX_IDLE) ||
                                   ((tx_state_q == TX_STOP) && (tx_cnt_q == '0)));
  assign tx_idle_c = tx_empty && (tx_state_q == TX_IDLE);
  assign tx_ovf_set_c = wr_data_c & tx_full;

  assign rx_stop_c     = (rx_state_q == RX_STOP) && (rx_cnt_q == '0);
  assign frm_err_set_c = rx_stop_c & ~rx_s2_q;
  assign rx_push_c     = rx_stop_c & rx_s2_q & ~rx_full;
  assign rx_ovr_set_c  = rx_stop_c & rx_s2_q & rx_full;
  assign rx_half_c     = DIV_W'((17'(div_q) + 17'd1) >> 1);

  assign unused_c = ^{tx_count, rx_count, bus.IO_WDATA[31:16]};

  assign UART_TX      = tx_q;
  assign IRQ          = irq_q;
  assign bus.IO_RDATA = rdata_q;

  io_fifo #(.DW(BYTE_W), .AW(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk(CLK), .rst_n(RESET_N), .push_i(wr_data_c), .wdata_i(bus.IO_WDATA[7:0]),
    .pop_i(tx_pop_c), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty),
    .count_o(tx_count));

  io_fifo #(.DW(BYTE_W), .AW(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk(CLK), .rst_n(RESET_N), .push_i(rx_push_c), .wdata_i(rx_sh_q),
    .pop_i(rd_data_c), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty),
    .count_o(rx_count));

  // STATUS word assembly
  always_comb begin
    status_c               = '0;
    status_c[ST_RX_VALID]  = ~rx_empty;
    status_c[ST_TX_FULL]   = tx_full;
    status_c[ST_TX_IDLE]   = tx_idle_c;
    status_c[ST_RX_OVR]    = rx_ovr_q;
    status_c[ST_FRAME_ERR] = frm_err_q;
    status_c[ST_TX_OVF]    = tx_ovf_q;
  end

  // Register file, read data, sticky flags and interrupt
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q     <= DEFAULT_DIV;
      ctrl_q    <= '0;
      rdata_q   <= '0;
      rx_ovr_q  <= 1'b0;
      frm_err_q <= 1'b0;
      tx_ovf_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (bus.IO_RE) begin
        unique case (bus.IO_ADDR)
          ADDR_DATA:   rdata_q <= rx_empty ? '0 : DATA_W'({1'b1, rx_head});
          ADDR_STATUS: rdata_q <= status_c;
          ADDR_DIV:    rdata_q <= DATA_W'(div_q);
          default:     rdata_q <= DATA_W'(ctrl_q);
        endcase
      end
      if (bus.IO_WE && (bus.IO_ADDR == ADDR_DIV))  div_q  <= bus.IO_WDATA[15:0];
      if (bus.IO_WE && (bus.IO_ADDR == ADDR_CTRL)) ctrl_q <= bus.IO_WDATA[1:0];
      // Set has priority over a same-cycle clear.
      rx_ovr_q  <= rx_ovr_set_c  | (rx_ovr_q  & ~clr_c[0]);
      frm_err_q <= frm_err_set_c | (frm_err_q & ~clr_c[1]);
      tx_ovf_q  <= tx_ovf_set_c  | (tx_ovf_q  & ~clr_c[2]);
      irq_q     <= (ctrl_q[CTRL_RX_IE] & ~rx_empty) | (ctrl_q[CTRL_TX_IE] & tx_empty);
    end
  end

  // TX shifter: every state lasts div_q+1 clocks, counter reloads per bit
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      unique case (tx_state_q)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_state_q <= TX_START;
            tx_cnt_q   <= div_q;
            tx_sh_q    <= tx_head;
            tx_q       <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= TX_DATA;
            tx_cnt_q   <= div_q;
            tx_bit_q   <= '0;
            tx_q       <= tx_sh_q[0];
            tx_sh_q    <= tx_sh_q >> 1;
          end else begin
            tx_cnt_q <= tx_cnt_q - DIV_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= div_q;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - DIV_W'(1);
          end
        end
        default: begin
          if (tx_cnt_q == '0) begin
            if (!tx_empty) begin
              tx_state_q <= TX_START;
              tx_cnt_q   <= div_q;
              tx_sh_q    <= tx_head;
              tx_q       <= 1'b0;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - DIV_W'(1);
          end
        end
      endcase
    end
  end

  // RX: synchronizer plus edge history, then centre-sampling receiver
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q <= UART_RX;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      unique case (rx_state_q)
        RX_IDLE: begin
          if (rx_s3_q && !rx_s2_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= (rx_half_c == '0) ? '0 : rx_half_c - DIV_W'(1);
          end
        end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            if (rx_s2_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_DATA;
              rx_cnt_q   <= div_q;
              rx_bit_q   <= '0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - DIV_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_cnt_q <= div_q;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - DIV_W'(1);
          end
        end
        default: begin
          if (rx_cnt_q == '0) rx_state_q <= RX_IDLE;
          else                rx_cnt_q   <= rx_cnt_q - DIV_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Directed self-checking bench for io_uart.
module tb_io_uart;
  import io_uart_pkg::*;

  logic CLK, RESET_N, UART_RX, UART_TX, IRQ;
  int   n_tests, n_fail;
  logic [31:0] rd;

  io_uart_if bus_if ();

  io_uart #(.FIFO_DEPTH_LOG2(3), .DEFAULT_DIV(16'd433)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus_if),
    .UART_RX(UART_RX), .UART_TX(UART_TX), .IRQ(IRQ));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus_if.IO_ADDR  = addr;
    bus_if.IO_WDATA = data;
    bus_if.IO_WE    = 1'b1;
    @(negedge CLK);
    bus_if.IO_WE    = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus_if.IO_ADDR = addr;
    bus_if.IO_RE   = 1'b1;
    @(negedge CLK);
    bus_if.IO_RE   = 1'b0;
    data = bus_if.IO_RDATA;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int per);
    UART_RX = 1'b0;
    repeat (per) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (per) @(negedge CLK);
    end
    UART_RX = stop_bit;
    repeat (per) @(negedge CLK);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    n_tests = 0;
    n_fail  = 0;
    RESET_N = 1'b0;
    UART_RX = 1'b1;
    bus_if.IO_ADDR  = '0;
    bus_if.IO_WE    = 1'b0;
    bus_if.IO_RE    = 1'b0;
    bus_if.IO_WDATA = '0;
    repeat (3) @(negedge CLK);
    check("rst_tx", 32'(UART_TX), 32'd1);
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_rdata", bus_if.IO_RDATA, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    bus_read(ADDR_STATUS, rd); check("rst_status", rd, 32'h04);
    bus_read(ADDR_DIV, rd);    check("rst_div", rd, 32'd433);

    // TX frame 0xA5 at DIV=3: start, LSB-first data, stop, 4 clocks each
    bus_write(ADDR_DIV, 32'd3);
    bus_write(ADDR_DATA, 32'hA5);
    frame = {1'b1, 8'hA5, 1'b0};
    @(posedge CLK);
    for (int i = 0; i < 10; i++) begin
      repeat (2) @(negedge CLK);
      check($sformatf("tx_bit%0d", i), 32'(UART_TX), 32'(frame[i]));
      repeat (3) @(posedge CLK);
    end
    @(negedge CLK);
    bus_read(ADDR_STATUS, rd); check("tx_done_status", rd, 32'h04);
    check("tx_idle_line", 32'(UART_TX), 32'd1);

    // TX FIFO fill with a slow shifter: first byte is popped, eight fill it
    bus_write(ADDR_DIV, 32'd1000);
    for (int i = 0; i < 9; i++) bus_write(ADDR_DATA, 32'(i));
    bus_read(ADDR_STATUS, rd); check("tx_full_no_ovf", rd, 32'h02);
    bus_write(ADDR_DATA, 32'h99);
    bus_read(ADDR_STATUS, rd); check("tx_ovf_set", rd, 32'h22);
    bus_write(ADDR_STATUS, 32'h20);
    bus_read(ADDR_STATUS, rd); check("tx_ovf_clr", rd, 32'h02);
    check("tx_in_start", 32'(UART_TX), 32'd0);

    // Reset mid-frame: line returns high at once, FIFOs empty
    RESET_N = 1'b0;
    #1;
    check("rst_mid_tx", 32'(UART_TX), 32'd1);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    bus_read(ADDR_STATUS, rd); check("rst_mid_status", rd, 32'h04);
    bus_read(ADDR_DIV, rd);    check("rst_mid_div", rd, 32'd433);

    // RX frame 0x3C at DIV=7
    bus_write(ADDR_DIV, 32'd7);
    send_rx(8'h3C, 1'b1, 8);
    bus_read(ADDR_STATUS, rd); check("rx_valid", rd, 32'h05);
    bus_read(ADDR_DATA, rd);   check("rx_data", rd, 32'h13C);
    bus_read(ADDR_DATA, rd);   check("rx_empty_read", rd, 32'h000);

    // Framing error, then a short glitch
    send_rx(8'h55, 1'b0, 8);
    UART_RX = 1'b1;
    repeat (8) @(negedge CLK);
    bus_read(ADDR_STATUS, rd); check("frame_err", rd, 32'h14);
    bus_write(ADDR_STATUS, 32'h10);
    bus_read(ADDR_STATUS, rd); check("frame_err_clr", rd, 32'h04);
    UART_RX = 1'b0;
    repeat (2) @(negedge CLK);
    UART_RX = 1'b1;
    repeat (24) @(negedge CLK);
    bus_read(ADDR_STATUS, rd); check("glitch", rd, 32'h04);

    // Nine frames without reading: overrun, first eight kept in order
    for (int i = 0; i < 9; i++) send_rx(8'h10 + 8'(i), 1'b1, 8);
    bus_read(ADDR_STATUS, rd); check("rx_overrun", rd, 32'h0D);
    for (int i = 0; i < 8; i++) begin
      bus_read(ADDR_DATA, rd);
      check($sformatf("rx_fifo%0d", i), rd, 32'h110 + 32'(i));
    end
    bus_read(ADDR_STATUS, rd); check("rx_drained", rd, 32'h0C);
    bus_write(ADDR_STATUS, 32'h08);
    bus_read(ADDR_STATUS, rd); check("rx_ovr_clr", rd, 32'h04);

    // RX interrupt and its one-cycle latency on pop
    bus_write(ADDR_CTRL, 32'h1);
    @(negedge CLK);
    check("irq_rx_idle", 32'(IRQ), 32'd0);
    send_rx(8'hA7, 1'b1, 8);
    check("irq_rx_set", 32'(IRQ), 32'd1);
    bus_read(ADDR_DATA, rd); check("irq_rx_data", rd, 32'h1A7);
    check("irq_lag", 32'(IRQ), 32'd1);
    @(negedge CLK);
    check("irq_rx_clr", 32'(IRQ), 32'd0);

    // TX-empty interrupt, CTRL and DIVISOR readback widths
    bus_write(ADDR_CTRL, 32'h2);
    @(negedge CLK);
    check("irq_tx_empty", 32'(IRQ), 32'd1);
    bus_read(ADDR_CTRL, rd); check("ctrl_rd", rd, 32'h2);
    bus_write(ADDR_DIV, 32'hFFFF_0007);
    bus_read(ADDR_DIV, rd);  check("div_upper", rd, 32'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_uart.md
Name: io_uart

Overview:
Memory-mapped 8N1 UART peripheral on the CPU IO bus, alongside phy_mem. It consumes CPU loads and stores decoded to the IO region and drives the serial TX/RX pins. Each direction has a FIFO, and a programmable baud divider sets the bit rate. A level interrupt output is provided for the exception unit.

Parameters:
FIFO_DEPTH_LOG2, 3, each FIFO holds 2^N bytes (8)
DEFAULT_DIV, 16'd433, reset value of DIVISOR; bit period = DIV+1 clocks

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
IO_ADDR  in  2  word offset: 0 DATA, 1 STATUS, 2 DIVISOR, 3 CTRL
IO_WE  in  1  write strobe, one cycle per access
IO_RE  in  1  read strobe, one cycle per access
IO_WDATA  in  32  write data
IO_RDATA  out  32  read data, registered
UART_RX  in  1  serial input, asynchronous, idle high
UART_TX  out  1  serial output, idle high
IRQ  out  1  level interrupt, registered

Behaviour:
- Reset (async, RESET_N=0):
  - UART_TX=1, IO_RDATA=0, IRQ=0.
  - Both FIFOs empty, sticky flags 0, DIVISOR=DEFAULT_DIV, CTRL=0.
  - TX and RX FSMs in IDLE.
  - Reset mid-frame aborts the frame immediately; TX returns high asynchronously.
- Read latency: IO_RDATA is valid the cycle after IO_RE and holds until the next IO_RE.
- DATA read: [7:0]=RX FIFO head, [8]=head valid, rest 0.
  - Pops the FIFO when non-empty.
  - Read when empty returns 0 and pops nothing.
- DATA write: pushes IO_WDATA[7:0] into the TX FIFO.
  - If the FIFO is full at the start of the cycle, the byte is dropped and tx_ovf is set.
  - A same-cycle pop by the shifter does not rescue the write.
- STATUS read, bit positions:
  - [0] rx_valid
  - [1] tx_full
  - [2] tx_idle (FIFO empty and FSM IDLE)
  - [3] rx_overrun
  - [4] frame_err
  - [5] tx_ovf
- STATUS write: 1s in bits [5:3] clear the matching sticky flags; other bits ignored.
  - Set and clear in the same cycle: set wins.
- DIVISOR: [15:0] read/write, upper bits read 0.
  - The bit counter reloads from DIVISOR at each bit boundary, so a write takes effect at the next bit.
  - Software changes DIVISOR only when tx_idle.
- CTRL: [0] rx_ie, [1] tx_ie.
  - IRQ <= (rx_ie & rx_valid) | (tx_ie & tx FIFO empty), registered one cycle.
- Simultaneous IO_WE and IO_RE: both honoured (different or same offset).
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE pops the FIFO when non-empty.
  - Each state lasts DIV+1 clocks.
  - DATA shifts 8 bits LSB first.
  - STOP drives 1 and then returns to IDLE; back-to-back bytes have no extra idle gap.
  - Frame = 10*(DIV+1) clocks.
- RX path: 2-flop synchronizer, then FSM IDLE -> START -> DATA -> STOP.
  - IDLE: on a sampled falling edge, wait (DIV+1)/2 clocks (integer division) to mid-start.
  - START: if the line is high at mid-start, the start was a glitch; return to IDLE, no flags.
  - DATA: sample 8 bits at bit centres, LSB first.
  - STOP, line=0 at stop centre: discard the byte, set frame_err.
  - STOP, valid byte with RX FIFO full: drop the byte, set rx_overrun.
  - Otherwise push the byte.
  - Return to IDLE at stop centre, so a new start can be detected during the second half of the stop bit.
- FIFO: push and pop in the same cycle on a non-empty, non-full FIFO leaves the count unchanged. Pointers wrap modulo depth; an extra bit distinguishes full from empty.

Decomposition:
- Package io_uart_pkg:
  - Register offset constants.
  - STATUS/CTRL bit index constants.
  - TX/RX FSM state enums.
- Sub-module io_fifo (parameter DW, AW; push/pop/full/empty/count), instantiated twice: TX and RX.
- The UART itself stays a single module.

Test Plan:
- Reset, DIV=3: write 0xA5 to DATA -> UART_TX low for 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, then high; STATUS[2]=1 at clk 40 after the pop.
- Write 9 bytes back-to-back with the shifter stalled → 8 accepted (the shifter pops first if it runs; check boundary with DIV large); 9th sets tx_ovf; write STATUS=0x20 -> bit 5 clears.
- Drive RX frame 0x3C at DIV=7 → STATUS[0]=1; read DATA -> IO_RDATA=0x13C next cycle; second read -> 0x000.
- RX frame with stop bit 0 -> STATUS[4]=1, rx_valid stays 0; 2-clk low glitch on RX -> no flags, no byte.
- Receive 9 frames without reading -> rx_overrun=1, first 8 bytes intact in order.
- CTRL=1, receive a byte -> IRQ rises 1 clk after rx_valid; RESET_N pulse mid-TX-frame -> UART_TX=1 immediately, FIFOs empty.
